// File: rtl/johnson_cntr_param.sv
// Parametrised N-bit Johnson counter with up/down stepping, index load,
// binary/one-hot decode, registered wrap pulse and illegal-state recovery.
module johnson_cntr_param #(
  parameter int N = 4,
  parameter int RESET_IDX = 0,
  localparam int IW = $clog2(2*N)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          dir,
  input  logic          load,
  input  logic [IW-1:0] load_idx,
  output logic [N-1:0]  state,
  output logic [IW-1:0] idx,
  output logic [2*N-1:0] dec,
  output logic          wrap,
  output logic          err
);

  // Index k fills the top k bits with ones; past N the ones drain from the top.
  function automatic logic [N-1:0] code_f(input int k);
    logic [N-1:0] c;
    c = '0;
    for (int i = 0; i < N; i++) begin
      if (k <= N) begin
        c[N-1-i] = (i < k);
      end else begin
        c[N-1-i] = (i >= k - N);
      end
    end
    return c;
  endfunction

  function automatic logic legal_f(input logic [N-1:0] s);
    int t;
    t = 0;
    for (int i = 0; i < N-1; i++) begin
      if (s[i] != s[i+1]) begin
        t++;
      end else begin
        t = t;
      end
    end
    return (t <= 1);
  endfunction

  // Valid only for legal codes: leading one means filling, leading zero means draining.
  function automatic logic [IW-1:0] index_f(input logic [N-1:0] s);
    int ones;
    ones = 0;
    for (int i = 0; i < N; i++) begin
      if (s[i]) begin
        ones++;
      end else begin
        ones = ones;
      end
    end
    if (s[N-1]) begin
      return IW'(ones);
    end else if (ones == 0) begin
      return '0;
    end else begin
      return IW'(2*N - ones);
    end
  endfunction

  localparam logic [N-1:0] RESET_CODE = code_f(RESET_IDX);

  logic [N-1:0]   state_r;
  logic           wrap_r;
  logic           err_r;
  logic [N-1:0]   state_nxt_s;
  logic           wrap_nxt_s;
  logic           err_nxt_s;
  logic           legal_s;
  logic           ld_ok_s;
  logic [IW-1:0]  idx_s;
  logic [2*N-1:0] dec_s;

  // Decode of the current state; illegal states report index 0 with no decode bit.
  always_comb begin
    legal_s = legal_f(state_r);
    idx_s   = '0;
    dec_s   = '0;
    if (legal_s) begin
      idx_s        = index_f(state_r);
      dec_s[idx_s] = 1'b1;
    end else begin
      idx_s = '0;
      dec_s = '0;
    end
  end

  // Next-state selection: load, then recovery, then step, then hold.
  always_comb begin
    state_nxt_s = state_r;
    wrap_nxt_s  = 1'b0;
    err_nxt_s   = err_r;
    ld_ok_s     = (int'(load_idx) < 2*N);
    if (load) begin
      if (ld_ok_s) begin
        state_nxt_s = code_f(int'(load_idx));
        err_nxt_s   = 1'b0;
      end else begin
        state_nxt_s = code_f(0);
        err_nxt_s   = 1'b1;
      end
    end else if (!legal_s) begin
      state_nxt_s = code_f(0);
      err_nxt_s   = 1'b1;
    end else if (en) begin
      if (dir) begin
        state_nxt_s = {~state_r[0], state_r[N-1:1]};
        wrap_nxt_s  = (idx_s == IW'(2*N-1));
      end else begin
        state_nxt_s = {state_r[N-2:0], ~state_r[N-1]};
        wrap_nxt_s  = (idx_s == IW'(0));
      end
    end else begin
      state_nxt_s = state_r;
      wrap_nxt_s  = 1'b0;
    end
  end

  // State, wrap and error registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= RESET_CODE;
      wrap_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      wrap_r  <= wrap_nxt_s;
      err_r   <= err_nxt_s;
    end
  end

  assign state = state_r;
  assign idx   = idx_s;
  assign dec   = dec_s;
  assign wrap  = wrap_r;
  assign err   = err_r;

endmodule

// File: tb/tb_johnson_cntr_param.sv
// Self-checking bench for johnson_cntr_param: directed plan plus random steps
// against an index-level model; a second N=3 instance covers out-of-range loads.
module tb_johnson_cntr_param;

  localparam int N  = 4;
  localparam int IW = 3;
  localparam int L  = 2*N;

  logic          clk = 1'b0;
  logic          rstn;
  logic          en, dir, load;
  logic [IW-1:0] load_idx;
  logic [N-1:0]  state;
  logic [IW-1:0] idx;
  logic [L-1:0]  dec;
  logic          wrap, err;

  logic          b_en, b_dir, b_load;
  logic [2:0]    b_load_idx;
  logic [2:0]    b_state;
  logic [2:0]    b_idx;
  logic [5:0]    b_dec;
  logic          b_wrap, b_err;

  int tests = 0;
  int fails = 0;

  int           m_idx;
  bit           m_legal;
  bit           m_err;
  bit           m_wrap;
  logic [N-1:0] m_forced;

  johnson_cntr_param #(.N(N), .RESET_IDX(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .dir(dir), .load(load), .load_idx(load_idx),
    .state(state), .idx(idx), .dec(dec), .wrap(wrap), .err(err)
  );

  johnson_cntr_param #(.N(3), .RESET_IDX(0)) dut_b (
    .clk(clk), .rstn(rstn), .en(b_en), .dir(b_dir), .load(b_load), .load_idx(b_load_idx),
    .state(b_state), .idx(b_idx), .dec(b_dec), .wrap(b_wrap), .err(b_err)
  );

  always #5 clk = ~clk;

  // Code for index k: a block of k ones at the top, or 2n-k ones at the bottom.
  function automatic int model_code(int n, int k);
    if (k <= n) return ((1 << k) - 1) << (n - k);
    else return (1 << (2*n - k)) - 1;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".state"}, 32'(state), m_legal ? 32'(model_code(N, m_idx)) : 32'(m_forced));
    check({tag, ".idx"},   32'(idx),   m_legal ? 32'(m_idx) : 32'd0);
    check({tag, ".dec"},   32'(dec),   m_legal ? (32'd1 << m_idx) : 32'd0);
    check({tag, ".wrap"},  32'(wrap),  32'(m_wrap));
    check({tag, ".err"},   32'(err),   32'(m_err));
  endtask

  task automatic model_reset();
    m_idx = 0; m_legal = 1'b1; m_err = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_edge();
    if (load) begin
      m_wrap = 1'b0; m_legal = 1'b1;
      if (int'(load_idx) < L) begin m_idx = int'(load_idx); m_err = 1'b0; end
      else begin m_idx = 0; m_err = 1'b1; end
    end else if (!m_legal) begin
      m_idx = 0; m_legal = 1'b1; m_err = 1'b1; m_wrap = 1'b0;
    end else if (en) begin
      if (dir) begin m_wrap = (m_idx == L-1); m_idx = (m_idx + 1) % L; end
      else begin m_wrap = (m_idx == 0); m_idx = (m_idx + L - 1) % L; end
    end else begin
      m_wrap = 1'b0;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; en = 1'b0; dir = 1'b1; load = 1'b0; load_idx = '0;
    b_en = 1'b0; b_dir = 1'b1; b_load = 1'b0; b_load_idx = '0;
    model_reset();
    #2;
    check_model("reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) begin tick(); check_model("hold"); end

    en = 1'b1; dir = 1'b1;
    for (int i = 0; i < 8; i++) begin tick(); check_model("fwd"); end
    tick(); check_model("fwd_post_wrap");

    // From index 1 walk back through 0 and wrap to 7.
    dir = 1'b0;
    tick(); check_model("rev_to0");
    tick(); check_model("rev_wrap");
    tick(); check_model("rev_2");
    dir = 1'b1;
    tick(); check_model("dir_toggle");
    dir = 1'b0;
    tick(); check_model("dir_back");

    load = 1'b1; load_idx = 3'd5; en = 1'b1;
    tick(); check_model("load5");
    load_idx = 3'd2;
    tick(); check_model("load2");
    load = 1'b0; en = 1'b0;

    @(negedge clk);
    force dut.state_r = 4'b0110;
    m_legal = 1'b0; m_forced = 4'b0110;
    #1;
    check_model("illegal_vis");
    release dut.state_r;
    tick(); check_model("recover");
    en = 1'b1;
    repeat (10) begin dir = 1'($urandom_range(0, 1)); tick(); check_model("err_sticky"); end
    load = 1'b1; load_idx = 3'd0;
    tick(); check_model("err_clear");

    load_idx = 3'd5;
    tick(); check_model("mid_load5");
    load = 1'b0; en = 1'b1; dir = 1'b1;
    #2;
    rstn = 1'b0;
    model_reset();
    #1;
    check_model("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    tick(); check_model("resume");

    for (int i = 0; i < 200; i++) begin
      en = 1'($urandom_range(0, 1));
      dir = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      load_idx = IW'($urandom_range(0, L-1));
      tick(); check_model("rand");
    end
    load = 1'b0; en = 1'b0;

    // N=3: indices 6 and 7 are out of range.
    b_load = 1'b1; b_load_idx = 3'd7;
    @(posedge clk); #1;
    check("b_oor7.state", 32'(b_state), 32'd0);
    check("b_oor7.err",   32'(b_err),   32'd1);
    check("b_oor7.dec",   32'(b_dec),   32'h01);
    b_load_idx = 3'd6;
    @(posedge clk); #1;
    check("b_oor6.err",   32'(b_err),   32'd1);
    b_load_idx = 3'd5;
    @(posedge clk); #1;
    check("b_load5.state", 32'(b_state), 32'h1);
    check("b_load5.idx",   32'(b_idx),   32'd5);
    check("b_load5.err",   32'(b_err),   32'd0);
    check("b_load5.dec",   32'(b_dec),   32'h20);
    b_load = 1'b0; b_en = 1'b1; b_dir = 1'b1;
    @(posedge clk); #1;
    check("b_wrap.state", 32'(b_state), 32'd0);
    check("b_wrap.wrap",  32'(b_wrap),  32'd1);
    @(posedge clk); #1;
    check("b_step.state", 32'(b_state), 32'h4);
    check("b_step.idx",   32'(b_idx),   32'd1);
    check("b_step.wrap",  32'(b_wrap),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
